// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared types and constants for the HD44780 4-bit command sequencer.
//   lcd_cmd_t    : {rs, nibble} as presented to lcd_transfer
//   seq_state_t  : sequencer FSM states
//   usToCycles() : microseconds to clock cycles, t1_uS = freq / 1000000
//   DEF_*        : default timing values in microseconds
package lcd_pkg;

   localparam int unsigned DELAY_W        = 21;
   localparam int unsigned MAX_DELAY_CYC  = (1 << DELAY_W) - 1;

   // 4100 us (the first init step) needs 13 bits.
   localparam int unsigned US_W           = 13;
   localparam int unsigned ROM_MAX_US     = 4100;
   localparam int unsigned ROM_LAST_IDX   = 13;

   localparam int unsigned DEF_FREQ       = 50000000;
   localparam int unsigned DEF_POWERUP_US = 15000;
   localparam int unsigned DEF_NIBBLE_US  = 1;
   localparam int unsigned DEF_CMD_US     = 40;
   localparam int unsigned DEF_SLOW_US    = 1640;

   typedef struct packed {
      logic       rs;
      logic [3:0] nib;
   } lcd_cmd_t;

   typedef enum logic [3:0] {
      PWR_WAIT,
      INIT_ISSUE,
      INIT_WAIT,
      GAP,
      READY,
      HI_ISSUE,
      HI_WAIT,
      LO_ISSUE,
      LO_WAIT
   } seq_state_t;

   function automatic int unsigned usToCycles(input int unsigned us, input int unsigned freq);
      return us * (freq / 1000000);
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom
// Combinational table of the 14-step 4-bit LCD init sequence.
//   idx_i     : step index 0..13
//   cmd_o     : {rs, nibble} for that step (rs is always 0 here)
//   delayUs_o : post-delay for that step in microseconds
//   last_o    : high on the final step
module lcd_init_rom
   import lcd_pkg::*;
#(
   parameter int unsigned NIBBLE_US = DEF_NIBBLE_US,
   parameter int unsigned CMD_US    = DEF_CMD_US,
   parameter int unsigned SLOW_US   = DEF_SLOW_US
)(
   input  logic [3:0]      idx_i,
   output lcd_cmd_t        cmd_o,
   output logic [US_W-1:0] delayUs_o,
   output logic            last_o
);

   localparam logic [US_W-1:0] NIB_US  = US_W'(NIBBLE_US);
   localparam logic [US_W-1:0] CMDL_US = US_W'(CMD_US);
   localparam logic [US_W-1:0] SLOWL_US = US_W'(SLOW_US);

   // Steps 0-3 are the raw wake-up nibbles that force 4-bit mode; steps
   // 4-13 are the bytes 0x28, 0x08, 0x01, 0x06, 0x0C split into hi/lo
   // nibbles. Only the clear (0x01) low nibble needs the long delay.
   always_comb begin
      cmd_o     = '0;
      delayUs_o = '0;
      last_o    = 1'b0;
      case (idx_i)
         4'd0:  begin cmd_o.nib = 4'h3; delayUs_o = US_W'(4100); end
         4'd1:  begin cmd_o.nib = 4'h3; delayUs_o = US_W'(100);  end
         4'd2:  begin cmd_o.nib = 4'h3; delayUs_o = US_W'(40);   end
         4'd3:  begin cmd_o.nib = 4'h2; delayUs_o = US_W'(40);   end
         4'd4:  begin cmd_o.nib = 4'h2; delayUs_o = NIB_US;      end
         4'd5:  begin cmd_o.nib = 4'h8; delayUs_o = CMDL_US;     end
         4'd6:  begin cmd_o.nib = 4'h0; delayUs_o = NIB_US;      end
         4'd7:  begin cmd_o.nib = 4'h8; delayUs_o = CMDL_US;     end
         4'd8:  begin cmd_o.nib = 4'h0; delayUs_o = NIB_US;      end
         4'd9:  begin cmd_o.nib = 4'h1; delayUs_o = SLOWL_US;    end
         4'd10: begin cmd_o.nib = 4'h0; delayUs_o = NIB_US;      end
         4'd11: begin cmd_o.nib = 4'h6; delayUs_o = CMDL_US;     end
         4'd12: begin cmd_o.nib = 4'h0; delayUs_o = NIB_US;      end
         4'd13: begin cmd_o.nib = 4'hC; delayUs_o = CMDL_US; last_o = 1'b1; end
         default: begin end
      endcase
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Sole master of lcd_transfer for a 4-bit HD44780 LCD. Waits out power-up,
// plays the init ROM, then turns each accepted application byte into a
// high and a low nibble transfer with the proper post-delays.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o : byte handshake (accept = valid && ready)
//   wr_rs_i, wr_data_i    : 0 = instruction, 1 = character; byte value
//   init_done_o           : init sequence complete, held until reset
//   busy_o                : low only while idle and able to accept
//   sendCommand_o         : one-cycle start pulse to lcd_transfer
//   command_o             : {rs, nibble}, held until the next start
//   commandDelay_o        : post-delay in cycles, held with command_o
//   commandDone_i         : one-cycle completion pulse from lcd_transfer
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned FREQ       = DEF_FREQ,
   parameter int unsigned POWERUP_US = DEF_POWERUP_US,
   parameter int unsigned NIBBLE_US  = DEF_NIBBLE_US,
   parameter int unsigned CMD_US     = DEF_CMD_US,
   parameter int unsigned SLOW_US    = DEF_SLOW_US
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_valid_i,
   input  logic        wr_rs_i,
   input  logic [7:0]  wr_data_i,
   output logic        wr_ready_o,
   output logic        init_done_o,
   output logic        busy_o,
   output logic        sendCommand_o,
   output logic [4:0]  command_o,
   output logic [20:0] commandDelay_o,
   input  logic        commandDone_i
);

   localparam int unsigned T1          = FREQ / 1000000;
   localparam int unsigned POWERUP_CYC = usToCycles(POWERUP_US, FREQ);
   localparam logic [DELAY_W-1:0] NIBBLE_CYC = DELAY_W'(usToCycles(NIBBLE_US, FREQ));
   localparam logic [DELAY_W-1:0] CMD_CYC    = DELAY_W'(usToCycles(CMD_US, FREQ));
   localparam logic [DELAY_W-1:0] SLOW_CYC   = DELAY_W'(usToCycles(SLOW_US, FREQ));

   // Refuse to build with a delay that cannot be expressed on commandDelay_o.
   if (usToCycles(ROM_MAX_US, FREQ) > MAX_DELAY_CYC ||
       usToCycles(NIBBLE_US, FREQ)  > MAX_DELAY_CYC ||
       usToCycles(CMD_US, FREQ)     > MAX_DELAY_CYC ||
       usToCycles(SLOW_US, FREQ)    > MAX_DELAY_CYC ||
       SLOW_US >= (1 << US_W) || POWERUP_CYC == 0) begin : gDelayRangeCheck
      $error("lcd_cmd_sequencer: delay parameter out of range");
   end

   seq_state_t   state_q, state_d;
   logic [31:0]  timer_q, timer_d;
   logic [3:0]   romIdx_q, romIdx_d;
   logic         initDone_q, initDone_d;
   logic         loPending_q, loPending_d;
   logic         rs_q, rs_d;
   logic [7:0]   byte_q, byte_d;
   lcd_cmd_t     cmd_q, cmd_d;
   logic [DELAY_W-1:0] delay_q, delay_d;

   lcd_cmd_t        romCmd;
   logic [US_W-1:0] romDelayUs;
   logic            romLast;
   logic [31:0]     romDelayWide;
   logic [DELAY_W-1:0] romDelayCyc;
   logic            isSlow;

   lcd_init_rom #(
      .NIBBLE_US (NIBBLE_US),
      .CMD_US    (CMD_US),
      .SLOW_US   (SLOW_US)
   ) uInitRom (
      .idx_i     (romIdx_q),
      .cmd_o     (romCmd),
      .delayUs_o (romDelayUs),
      .last_o    (romLast)
   );

   assign romDelayWide = 32'(romDelayUs) * T1;
   assign romDelayCyc  = DELAY_W'(romDelayWide);

   // Clear and home are the only instructions that need the long settle time.
   assign isSlow = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);

   // State and datapath registers. command/delay are only reloaded on the
   // way into an ISSUE state, so they stay stable for the whole transfer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= PWR_WAIT;
         timer_q     <= '0;
         romIdx_q    <= '0;
         initDone_q  <= 1'b0;
         loPending_q <= 1'b0;
         rs_q        <= 1'b0;
         byte_q      <= '0;
         cmd_q       <= '0;
         delay_q     <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         romIdx_q    <= romIdx_d;
         initDone_q  <= initDone_d;
         loPending_q <= loPending_d;
         rs_q        <= rs_d;
         byte_q      <= byte_d;
         cmd_q       <= cmd_d;
         delay_q     <= delay_d;
      end
   end

   // Next-state logic. GAP is a single shared cycle after every completion
   // that covers lcd_transfer's done_tick state; where it goes next depends
   // on whether init is still running and whether a low nibble is pending.
   // commandDone_i only matters in the *_WAIT states.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      romIdx_d    = romIdx_q;
      initDone_d  = initDone_q;
      loPending_d = loPending_q;
      rs_d        = rs_q;
      byte_d      = byte_q;
      cmd_d       = cmd_q;
      delay_d     = delay_q;
      case (state_q)
         PWR_WAIT: begin
            if (timer_q == POWERUP_CYC - 1) begin
               state_d = INIT_ISSUE;
               timer_d = '0;
               cmd_d   = romCmd;
               delay_d = romDelayCyc;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         INIT_ISSUE: state_d = INIT_WAIT;
         INIT_WAIT: begin
            if (commandDone_i) begin
               state_d = GAP;
               if (romLast) begin
                  initDone_d = 1'b1;
               end else begin
                  romIdx_d = romIdx_q + 4'd1;
               end
            end
         end
         GAP: begin
            if (!initDone_q) begin
               state_d = INIT_ISSUE;
               cmd_d   = romCmd;
               delay_d = romDelayCyc;
            end else if (loPending_q) begin
               state_d     = LO_ISSUE;
               loPending_d = 1'b0;
               cmd_d.rs    = rs_q;
               cmd_d.nib   = byte_q[3:0];
               delay_d     = isSlow ? SLOW_CYC : CMD_CYC;
            end else begin
               state_d = READY;
            end
         end
         READY: begin
            if (wr_valid_i) begin
               state_d   = HI_ISSUE;
               rs_d      = wr_rs_i;
               byte_d    = wr_data_i;
               cmd_d.rs  = wr_rs_i;
               cmd_d.nib = wr_data_i[7:4];
               delay_d   = NIBBLE_CYC;
            end
         end
         HI_ISSUE: state_d = HI_WAIT;
         HI_WAIT: begin
            if (commandDone_i) begin
               state_d     = GAP;
               loPending_d = 1'b1;
            end
         end
         LO_ISSUE: state_d = LO_WAIT;
         LO_WAIT: begin
            if (commandDone_i) begin
               state_d = GAP;
            end
         end
         default: state_d = PWR_WAIT;
      endcase
   end

   // Outputs decoded from the current state: one start pulse per ISSUE
   // state, and the write port is open only in READY.
   always_comb begin
      sendCommand_o = 1'b0;
      wr_ready_o    = 1'b0;
      busy_o        = 1'b1;
      case (state_q)
         INIT_ISSUE, HI_ISSUE, LO_ISSUE: sendCommand_o = 1'b1;
         READY: begin
            wr_ready_o = 1'b1;
            busy_o     = 1'b0;
         end
         default: begin end
      endcase
   end

   assign command_o      = cmd_q;
   assign commandDelay_o = delay_q;
   assign init_done_o    = initDone_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer
// Self-checking bench for lcd_cmd_sequencer at FREQ = 1 MHz (1 cycle = 1 us).
// A behavioural lcd_transfer stand-in answers every start pulse with a
// commandDone after a random latency and logs what it was asked to do.
// Expected nibbles/delays come from a byte-level model of the LCD protocol.
module tb_lcd_cmd_sequencer;

   localparam int unsigned FREQ    = 1000000;
   localparam int          POWERUP = 15000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrValid = 1'b0;
   logic        wrRs = 1'b0;
   logic [7:0]  wrData = 8'h00;
   logic        wrReady, initDone, busy, sendCommand;
   logic [4:0]  command;
   logic [20:0] commandDelay;
   logic        modelDone = 1'b0;
   logic        injectDone = 1'b0;
   logic        commandDone;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int relCyc = 0;

   // Transfer log filled by the lcd_transfer stand-in.
   logic [4:0]  pCmd[$];
   logic [20:0] pDly[$];
   int          pCyc[$];
   int          dCyc[$];
   int          lastDone = -100;
   int          protoErrs = 0;
   bit          xferBusy = 1'b0;
   int          xferCnt = 0;

   // Expected transfers from the reference model.
   logic [4:0]  eCmd[$];
   logic [20:0] eDly[$];

   assign commandDone = modelDone | injectDone;

   lcd_cmd_sequencer #(.FREQ(FREQ)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_valid_i     (wrValid),
      .wr_rs_i        (wrRs),
      .wr_data_i      (wrData),
      .wr_ready_o     (wrReady),
      .init_done_o    (initDone),
      .busy_o         (busy),
      .sendCommand_o  (sendCommand),
      .command_o      (command),
      .commandDelay_o (commandDelay),
      .commandDone_i  (commandDone)
   );

   always #5 clk = ~clk;

   // Cycle counter; the value seen between edges names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // lcd_transfer stand-in: logs each start, flags a start while a transfer
   // is outstanding or sooner than two cycles after a done, and returns a
   // one-cycle done 1..6 cycles after the start. It keeps running across
   // reset so an in-flight transfer drains as the real block would.
   always @(negedge clk) begin
      modelDone = 1'b0;
      if (xferBusy) begin
         if (xferCnt == 0) begin
            modelDone = 1'b1;
            xferBusy  = 1'b0;
            lastDone  = cyc;
            dCyc.push_back(cyc);
         end else begin
            xferCnt--;
         end
      end
      if (sendCommand === 1'b1) begin
         if (xferBusy || (cyc - lastDone) < 2) protoErrs++;
         pCmd.push_back(command);
         pDly.push_back(commandDelay);
         pCyc.push_back(cyc);
         xferBusy = 1'b1;
         xferCnt  = int'($urandom_range(5, 0));
      end
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clearLogs();
      pCmd.delete(); pDly.delete(); pCyc.delete(); dCyc.delete();
      eCmd.delete(); eDly.delete();
   endtask

   // Reference model of one byte write: high nibble with the short delay,
   // low nibble with 40 us, or 1640 us for clear/home instructions.
   function automatic void expectByte(input logic rs, input logic [7:0] b);
      eCmd.push_back({rs, b[7:4]});
      eDly.push_back(21'd1);
      eCmd.push_back({rs, b[3:0]});
      eDly.push_back((!rs && (b == 8'h01 || b == 8'h02)) ? 21'd1640 : 21'd40);
   endfunction

   // Presents one byte and holds it until accepted; acc is the accept cycle.
   task automatic applyStimulus(input logic rs, input logic [7:0] data, output int acc);
      int n = 0;
      acc = -1;
      wrRs = rs; wrData = data; wrValid = 1'b1;
      while (wrReady !== 1'b1 && n < 500) begin tick(); n++; end
      if (wrReady === 1'b1) acc = cyc;
      tick();
      wrValid = 1'b0;
   endtask

   task automatic waitReady(output bit ok);
      int n = 0;
      while (wrReady !== 1'b1 && n < 500) begin tick(); n++; end
      ok = (wrReady === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; wrValid = 1'b0;
      repeat (10) tick();
      compared++;
      if ({sendCommand, command, commandDelay, wrReady, initDone, busy} !== {1'b0, 5'h00, 21'd0, 1'b0, 1'b0, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got send=%b cmd=%h dly=%0d rdy=%b done=%b busy=%b, expected 0 00 0 0 0 1",
                  sendCommand, command, commandDelay, wrReady, initDone, busy);
      end
      clearLogs();
      rst = 1'b0;
      relCyc = cyc;
   endtask

   task automatic test_power_up();
      int n = 0;
      while (sendCommand !== 1'b1 && n < POWERUP + 200) begin tick(); n++; end
      compared++;
      if (pCyc.size() == 0 || pCyc[0] - relCyc != POWERUP) begin
         mismatched++;
         $display("[TB] FAIL powerup_latency: got %0d cycles, expected %0d",
                  (pCyc.size() == 0) ? -1 : pCyc[0] - relCyc, POWERUP);
      end
      compared++;
      if (pCmd.size() == 0 || {pCmd[0], pDly[0]} !== {5'h03, 21'd4100}) begin
         mismatched++;
         $display("[TB] FAIL powerup_first_cmd: got cmd=%h dly=%0d, expected cmd=03 dly=4100",
                  (pCmd.size() == 0) ? 5'h1F : pCmd[0], (pDly.size() == 0) ? 21'd0 : pDly[0]);
      end
   endtask

   task automatic test_init();
      logic [7:0] initBytes[5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
      int n = 0;
      int initCyc;
      eCmd.delete(); eDly.delete();
      eCmd.push_back(5'h03); eDly.push_back(21'd4100);
      eCmd.push_back(5'h03); eDly.push_back(21'd100);
      eCmd.push_back(5'h03); eDly.push_back(21'd40);
      eCmd.push_back(5'h02); eDly.push_back(21'd40);
      for (int i = 0; i < 5; i++) expectByte(1'b0, initBytes[i]);
      while (initDone !== 1'b1 && n < 3000) begin
         compared++;
         if (wrReady !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL init_ready_early: got wr_ready=%b at cycle %0d, expected 0", wrReady, cyc);
         end
         tick(); n++;
      end
      initCyc = cyc;
      compared++;
      if (initDone !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL init_timeout: got init_done=%b, expected 1", initDone);
      end
      compared++;
      if (pCmd.size() != 14) begin
         mismatched++;
         $display("[TB] FAIL init_count: got %0d pulses, expected 14", pCmd.size());
      end
      for (int i = 0; i < 14 && i < pCmd.size(); i++) begin
         compared++;
         if ({pCmd[i], pDly[i]} !== {eCmd[i], eDly[i]}) begin
            mismatched++;
            $display("[TB] FAIL init_step%0d: got cmd=%h dly=%0d, expected cmd=%h dly=%0d",
                     i, pCmd[i], pDly[i], eCmd[i], eDly[i]);
         end
      end
      compared++;
      if (dCyc.size() == 0 || initCyc != dCyc[$] + 1) begin
         mismatched++;
         $display("[TB] FAIL init_done_timing: got cycle %0d, expected %0d",
                  initCyc, (dCyc.size() == 0) ? -1 : dCyc[$] + 1);
      end
      compared++;
      if (wrReady !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL init_ready_gap: got wr_ready=%b, expected 0", wrReady);
      end
      tick();
      compared++;
      if ({wrReady, busy} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL init_ready: got ready/busy=%b, expected 10", {wrReady, busy});
      end
   endtask

   task automatic test_char_write();
      int acc;
      bit ok;
      clearLogs();
      expectByte(1'b1, 8'h41);
      applyStimulus(1'b1, 8'h41, acc);
      waitReady(ok);
      compared++;
      if (!ok || pCmd.size() != 2) begin
         mismatched++;
         $display("[TB] FAIL char_count: got ready=%b pulses=%0d, expected 1 and 2", ok, pCmd.size());
      end
      for (int i = 0; i < 2 && i < pCmd.size(); i++) begin
         compared++;
         if ({pCmd[i], pDly[i]} !== {eCmd[i], eDly[i]}) begin
            mismatched++;
            $display("[TB] FAIL char_nibble%0d: got cmd=%h dly=%0d, expected cmd=%h dly=%0d",
                     i, pCmd[i], pDly[i], eCmd[i], eDly[i]);
         end
      end
      compared++;
      if (pCyc.size() < 1 || pCyc[0] != acc + 1) begin
         mismatched++;
         $display("[TB] FAIL char_latency: got pulse at %0d, expected %0d",
                  (pCyc.size() < 1) ? -1 : pCyc[0], acc + 1);
      end
      compared++;
      if (pCyc.size() < 2 || dCyc.size() < 1 || pCyc[1] != dCyc[0] + 2) begin
         mismatched++;
         $display("[TB] FAIL char_gap: got second pulse at %0d, expected %0d",
                  (pCyc.size() < 2) ? -1 : pCyc[1], (dCyc.size() < 1) ? -1 : dCyc[0] + 2);
      end
   endtask

   task automatic test_back_to_back();
      logic       rs2;
      logic [7:0] d2;
      int accepts = 0;
      int n = 0;
      int acc2 = -1;
      bit ok;
      clearLogs();
      rs2 = 1'($urandom_range(1, 0));
      d2  = 8'($urandom_range(255, 0));
      expectByte(1'b0, 8'h01);
      expectByte(rs2, d2);
      wrRs = 1'b0; wrData = 8'h01; wrValid = 1'b1;
      while (accepts < 2 && n < 1000) begin
         if (wrReady === 1'b1) begin
            accepts++;
            if (accepts == 2) acc2 = cyc;
            tick(); n++;
            if (accepts == 1) begin wrRs = rs2; wrData = d2; end
         end else begin
            tick(); n++;
         end
      end
      wrValid = 1'b0;
      waitReady(ok);
      compared++;
      if (accepts != 2 || pCmd.size() != 4) begin
         mismatched++;
         $display("[TB] FAIL held_count: got accepts=%0d pulses=%0d, expected 2 and 4", accepts, pCmd.size());
      end
      for (int i = 0; i < 4 && i < pCmd.size(); i++) begin
         compared++;
         if ({pCmd[i], pDly[i]} !== {eCmd[i], eDly[i]}) begin
            mismatched++;
            $display("[TB] FAIL held_nibble%0d: got cmd=%h dly=%0d, expected cmd=%h dly=%0d",
                     i, pCmd[i], pDly[i], eCmd[i], eDly[i]);
         end
      end
      compared++;
      if (dCyc.size() < 2 || acc2 != dCyc[1] + 2) begin
         mismatched++;
         $display("[TB] FAIL held_second_accept: got cycle %0d, expected %0d",
                  acc2, (dCyc.size() < 2) ? -1 : dCyc[1] + 2);
      end
   endtask

   task automatic test_random_writes();
      logic       rs;
      logic [7:0] d;
      int acc;
      bit ok;
      for (int k = 0; k < 10; k++) begin
         clearLogs();
         rs = 1'($urandom_range(1, 0));
         d  = 8'($urandom_range(255, 0));
         if ($urandom_range(3, 0) == 0) begin
            rs = 1'b0;
            d  = 8'($urandom_range(2, 1));
         end
         expectByte(rs, d);
         repeat ($urandom_range(3, 0)) tick();
         applyStimulus(rs, d, acc);
         waitReady(ok);
         compared++;
         if (!ok || pCmd.size() != 2 || pCyc[0] != acc + 1) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_count: got ready=%b pulses=%0d, expected 1 and 2 starting at %0d",
                     k, ok, pCmd.size(), acc + 1);
         end
         for (int i = 0; i < 2 && i < pCmd.size(); i++) begin
            compared++;
            if ({pCmd[i], pDly[i]} !== {eCmd[i], eDly[i]}) begin
               mismatched++;
               $display("[TB] FAIL rand%0d_nibble%0d: got cmd=%h dly=%0d, expected cmd=%h dly=%0d",
                        k, i, pCmd[i], pDly[i], eCmd[i], eDly[i]);
            end
         end
      end
   endtask

   task automatic test_stray_done();
      bit bad = 1'b0;
      clearLogs();
      injectDone = 1'b1;
      tick();
      injectDone = 1'b0;
      repeat (10) begin
         tick();
         if (wrReady !== 1'b1 || busy !== 1'b0 || sendCommand !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad || pCmd.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL stray_done_ready: got disturbed=%b pulses=%0d, expected 0 and 0", bad, pCmd.size());
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      int n = 0;
      clearLogs();
      applyStimulus(1'b0, 8'h01, acc);
      while (pCmd.size() < 2 && n < 200) begin tick(); n++; end
      tick();
      rst = 1'b1;
      tick();
      compared++;
      if ({sendCommand, command, commandDelay, wrReady, initDone, busy} !== {1'b0, 5'h00, 21'd0, 1'b0, 1'b0, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL midreset_values: got send=%b cmd=%h dly=%0d rdy=%b done=%b busy=%b, expected 0 00 0 0 0 1",
                  sendCommand, command, commandDelay, wrReady, initDone, busy);
      end
      repeat (5) tick();
      clearLogs();
      rst = 1'b0;
      relCyc = cyc;
      repeat (50) tick();
      injectDone = 1'b1;
      tick();
      injectDone = 1'b0;
      tick();
      compared++;
      if ({initDone, busy, wrReady} !== 3'b010 || pCmd.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL midreset_stray: got done/busy/rdy=%b pulses=%0d, expected 010 and 0",
                  {initDone, busy, wrReady}, pCmd.size());
      end
   endtask

   task automatic test_protocol();
      compared++;
      if (protoErrs != 0) begin
         mismatched++;
         $display("[TB] FAIL protocol: got %0d handshake violations, expected 0", protoErrs);
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_init();
      test_char_write();
      test_back_to_back();
      test_random_writes();
      test_stray_done();
      test_reset_mid();
      test_power_up();
      test_init();
      test_char_write();
      test_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
